kernel_bc_word_split: RTL and testbench

Downstream consumer of the 64-bit, depth-2 shift-register FIFO in the BC kernel datapath. It pops a run-time count of 64-bit packed words from that FIFO and emits each as two 32-bit words, low half first, into a 32-bit output FIFO. It sustains one 32-bit word per cycle under full backpressure tolerance. Start and completion are controlled with an ap_ctrl_hs-style handshake from the kernel control FSM.

---
 rtl/kernel_bc_word_split.sv | 86 ++++++++
 tb/tb_kernel_bc_word_split.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_bc_word_split.sv
// Splits each 64-bit word popped from the upstream FIFO into two 32-bit pushes,
// low half first, under an ap_ctrl_hs start/done handshake.
module kernel_bc_word_split #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_idle,
    output logic                 ap_ready,
    input  logic [CNT_WIDTH-1:0] num_words,
    input  logic                 in_empty_n,
    output logic                 in_read,
    input  logic [IN_WIDTH-1:0]  in_dout,
    input  logic                 out_full_n,
    output logic                 out_write,
    output logic [OUT_WIDTH-1:0] out_din,
    output logic [CNT_WIDTH-1:0] out_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t               state, state_next;
    logic [IN_WIDTH-1:0]  hold;
    logic                 hold_valid;
    logic                 half;
    logic [CNT_WIDTH-1:0] rd_left;
    logic                 running;

    always_comb begin
        running    = ap_rst_n && (state == S_RUN);
        ap_idle    = (state == S_IDLE);
        ap_done    = (state == S_DONE);
        ap_ready   = (state == S_DONE);
        out_din    = half ? hold[IN_WIDTH-1:OUT_WIDTH] : hold[OUT_WIDTH-1:0];
        out_write  = running && hold_valid && out_full_n;
        // Refill is allowed in the same cycle the high half drains, so no bubble.
        in_read    = running && in_empty_n && (rd_left != '0) &&
                     (!hold_valid || (half && out_full_n));
        state_next = state;
        case (state)
            S_IDLE: if (ap_start) state_next = (num_words == '0) ? S_DONE : S_RUN;
            S_RUN:  if (out_write && half && (rd_left == '0) && !in_read) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state      <= S_IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            half       <= 1'b0;
            rd_left    <= '0;
            out_count  <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE) begin
                if (ap_start) begin
                    rd_left    <= num_words;
                    out_count  <= '0;
                    hold_valid <= 1'b0;
                    half       <= 1'b0;
                end
            end else if (state == S_RUN) begin
                if (in_read) begin
                    hold       <= in_dout;
                    hold_valid <= 1'b1;
                    half       <= 1'b0;
                    rd_left    <= rd_left - CNT_ONE;
                end else if (out_write) begin
                    if (!half) half       <= 1'b1;
                    else       hold_valid <= 1'b0;
                end
                if (out_write) out_count <= out_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_kernel_bc_word_split.sv
// Self-checking bench: upstream FIFO as a queue, expected output stream and
// per-cycle read/write enables derived from pop/push counts of the current job.
module tb_kernel_bc_word_split;

    localparam int IW = 64;
    localparam int OW = 32;
    localparam int CW = 32;

    logic          ap_clk, ap_rst_n, ap_start;
    logic          ap_done, ap_idle, ap_ready;
    logic [CW-1:0] num_words;
    logic          in_empty_n, in_read;
    logic [IW-1:0] in_dout;
    logic          out_full_n, out_write;
    logic [OW-1:0] out_din;
    logic [CW-1:0] out_count;

    kernel_bc_word_split #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .num_words(num_words), .in_empty_n(in_empty_n), .in_read(in_read),
        .in_dout(in_dout), .out_full_n(out_full_n), .out_write(out_write),
        .out_din(out_din), .out_count(out_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] up_q[$];
    logic [OW-1:0] exp_out[$];
    int            wr_cyc[$];
    logic [OW-1:0] wr_val[$];
    bit  pop_flag = 0;
    bit  job_active = 0;
    bit  gate = 1;
    int  cyc = 0;
    int  jn = 0, jr = 0, jp = 0;
    int  start_cyc = 0, done_cyc = 0, last_push_cyc = 0, done_cnt = 0, tot_push = 0;
    int  bp_mode = 0, bp_ph = 0, full_pct = 100, empty_pct = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor and reference model: sampled on the falling edge.
    always @(negedge ap_clk) begin
        logic exp_rd, exp_wr;
        cyc++;
        if (!ap_rst_n) begin
            chk("rst_in_read", in_read, 0);
            chk("rst_out_write", out_write, 0);
            job_active = 0;
            exp_out.delete();
            pop_flag = 0;
        end else begin
            exp_rd = job_active && in_empty_n && (jr < jn) &&
                     ((jp == 2*jr) || ((jp == 2*jr - 1) && out_full_n));
            exp_wr = job_active && (jp < 2*jr) && out_full_n;
            chk("in_read", in_read, exp_rd);
            chk("out_write", out_write, exp_wr);
            chk("ready_eq_done", ap_ready, ap_done);
            chk("idle", ap_idle, !job_active);
            if (job_active) chk("out_count", out_count, jp);
            if (job_active && (jp < 2*jr) && exp_out.size() > 0)
                chk("out_din", out_din, exp_out[0]);
            if (out_write) begin
                if (exp_out.size() > 0) void'(exp_out.pop_front());
                jp++; tot_push++;
                wr_cyc.push_back(cyc); wr_val.push_back(out_din);
                last_push_cyc = cyc;
            end
            if (in_read) jr++;
            pop_flag = in_read;
            if (ap_done) begin
                chk("done_in_job", job_active, 1);
                if (job_active) begin
                    chk("done_pushes", jp, 2*jn);
                    chk("done_reads", jr, jn);
                    chk("done_cycle", cyc, (jn == 0) ? start_cyc + 1 : last_push_cyc + 1);
                end
                done_cyc = cyc;
                done_cnt++;
                job_active = 0;
            end
            if (ap_idle && ap_start) begin
                job_active = 1;
                jn = num_words; jr = 0; jp = 0;
                start_cyc = cyc;
                exp_out.delete(); wr_cyc.delete(); wr_val.delete();
                for (int i = 0; i < jn && i < up_q.size(); i++) begin
                    logic [IW-1:0] w;
                    w = up_q[i];
                    exp_out.push_back(w[OW-1:0]);
                    exp_out.push_back(w[IW-1:OW]);
                end
            end
        end
    end

    task automatic refresh();
        in_empty_n = gate && (up_q.size() > 0);
        in_dout    = (up_q.size() > 0) ? up_q[0] : '0;
    endtask

    task automatic step();
        @(posedge ap_clk); #1;
        if (pop_flag) begin
            if (up_q.size() > 0) void'(up_q.pop_front());
            pop_flag = 0;
        end
        case (bp_mode)
            0: out_full_n = 1'b1;
            1: begin out_full_n = (bp_ph % 3 == 0); bp_ph++; end
            default: out_full_n = ($urandom_range(0, 99) < full_pct);
        endcase
        gate = (empty_pct == 0) || ($urandom_range(0, 99) >= empty_pct);
        refresh();
    endtask

    task automatic start_job(input int n, input bit keep);
        num_words = n;
        ap_start  = 1'b1;
        step();
        if (!keep) ap_start = 1'b0;
        num_words = $urandom;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) step();
        chk("job_done", done_cnt != d0, 1);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) up_q.push_back({$urandom, $urandom});
        refresh();
    endtask

    initial begin
        int d1, tp0, dc0;
        ap_rst_n = 0; ap_start = 0; num_words = '0;
        in_empty_n = 0; in_dout = '0; out_full_n = 1;
        repeat (3) step();
        ap_rst_n = 1;
        step();
        chk("reset_idle", ap_idle, 1);
        chk("reset_done", ap_done, 0);
        chk("reset_ready", ap_ready, 0);
        chk("reset_in_read", in_read, 0);
        chk("reset_out_write", out_write, 0);
        chk("reset_out_din", out_din, 0);
        chk("reset_out_count", out_count, 0);

        // Basic three-word job with literal expectations.
        up_q.push_back(64'h00000002_00000001);
        up_q.push_back(64'h00000004_00000003);
        up_q.push_back(64'h00000006_00000005);
        refresh();
        start_job(3, 0);
        wait_done(40);
        chk("t1_out_count", out_count, 6);
        chk("t1_npush", wr_val.size(), 6);
        for (int i = 0; i < 6 && i < wr_val.size(); i++) begin
            chk("t1_val", wr_val[i], i + 1);
            chk("t1_cyc", wr_cyc[i], start_cyc + 2 + i);
        end
        chk("t1_done_cyc", done_cyc, start_cyc + 8);
        step();

        // Zero-length job.
        load(2);
        start_job(0, 0);
        wait_done(10);
        chk("t2_npush", wr_val.size(), 0);
        chk("t2_reads", jr, 0);
        chk("t2_out_count", out_count, 0);
        chk("t2_done_cyc", done_cyc, start_cyc + 1);
        up_q.delete(); refresh();
        step();

        // Toggling backpressure.
        bp_mode = 1; bp_ph = 0;
        load(4);
        start_job(4, 0);
        wait_done(100);
        chk("t3_out_count", out_count, 8);
        chk("t3_reads", jr, 4);
        bp_mode = 0;
        up_q.delete(); refresh();
        step();

        // Upstream starvation between words.
        load(1);
        start_job(2, 0);
        for (int i = 0; i < 20 && jr < 1; i++) step();
        repeat (5) step();
        load(1);
        wait_done(40);
        chk("t4_npush", wr_val.size(), 4);
        if (wr_cyc.size() == 4) chk("t4_gap", (wr_cyc[2] - wr_cyc[1]) > 1, 1);
        step();

        // Reset mid-job, then a fresh one-word job.
        load(4);
        start_job(4, 0);
        for (int i = 0; i < 30 && jp < 3; i++) step();
        ap_rst_n = 0;
        step();
        ap_rst_n = 1;
        chk("t5_idle", ap_idle, 1);
        chk("t5_out_count", out_count, 0);
        start_job(1, 0);
        wait_done(20);
        chk("t5_npush", wr_val.size(), 2);
        chk("t5_out_count2", out_count, 2);
        up_q.delete(); refresh();
        step();

        // Held start across two jobs.
        load(2);
        tp0 = tot_push; dc0 = done_cnt;
        start_job(1, 1);
        num_words = 1;
        wait_done(20);
        d1 = done_cyc;
        wait_done(20);
        ap_start = 0;
        chk("t6_restart_cyc", start_cyc, d1 + 1);
        chk("t6_dones", done_cnt - dc0, 2);
        chk("t6_pushes", tot_push - tp0, 4);
        up_q.delete(); refresh();
        step();

        // Randomized jobs with random backpressure and starvation.
        bp_mode = 2;
        for (int j = 0; j < 30; j++) begin
            int n;
            n = $urandom_range(0, 6);
            full_pct  = $urandom_range(30, 100);
            empty_pct = $urandom_range(0, 50);
            load(n + $urandom_range(0, 2));
            start_job(n, 0);
            wait_done(400);
            chk("rand_out_count", out_count, 2*n);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
